// File: rtl/fb_pixel_writer.sv
// Scanner-to-framebuffer pixel writer: address pipeline, write FIFO and frame-completion FSM.
// Optional bounds clipping of incoming pixels is enabled by defining PIXEL_WRITER_CLIP_EN.
module fb_pixel_writer #(
  parameter int CORDW  = 10,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int COLRW  = 4,
  parameter int ADDRW  = 19,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CORDW-1:0] x,
  input  logic [CORDW-1:0] y,
  input  logic             drawing,
  input  logic [COLRW-1:0] colr,
  input  logic             frame_done,
  output logic             oe,
  output logic [ADDRW-1:0] mem_addr,
  output logic [COLRW-1:0] mem_data,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int ENTW = ADDRW + COLRW;

`ifdef PIXEL_WRITER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Linear address y*WIDTH + x, wrapping modulo 2**ADDRW.
  function automatic logic [ADDRW-1:0] calc_addr(input logic [CORDW-1:0] px,
                                                 input logic [CORDW-1:0] py);
    calc_addr = ADDRW'(py) * ADDRW'(WIDTH) + ADDRW'(px);
  endfunction

  function automatic logic in_frame(input logic [CORDW-1:0] px,
                                    input logic [CORDW-1:0] py);
    in_frame = (32'(px) < 32'(WIDTH)) && (32'(py) < 32'(HEIGHT));
  endfunction

  state_t            state;
  logic              keep;
  logic              vld_p1;
  logic [ADDRW-1:0]  addr_p1;
  logic [COLRW-1:0]  colr_p1;

  logic [ENTW-1:0]   fifo_mem [DEPTH];
  logic [PTRW-1:0]   wr_ptr;
  logic [PTRW-1:0]   rd_ptr;
  logic [CNTW-1:0]   cnt;
  logic [CNTW-1:0]   cnt_nxt;
  logic [ENTW-1:0]   head;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;
  logic              drained;

  assign keep = drawing && (!CLIP || in_frame(x, y));

  // Stage 1: register the pixel and its framebuffer address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= keep;
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      addr_p1 <= calc_addr(x, y);
      colr_p1 <= colr;
    end
  end

  // Stage 2: push into the write FIFO; a full FIFO can still take the pixel if the head leaves
  assign empty   = (cnt == '0);
  assign full    = (cnt == CNTW'(DEPTH));
  assign pop     = mem_we && mem_ready;
  assign push    = vld_p1 && (!full || pop);
  assign drop    = vld_p1 && full && !pop;
  assign cnt_nxt = cnt + CNTW'(push) - CNTW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      cnt <= cnt_nxt;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {addr_p1, colr_p1};
  end

  // Memory side: the head is presented unchanged until the memory takes it
  assign head     = fifo_mem[rd_ptr];
  assign mem_we   = !empty;
  assign mem_addr = empty ? '0 : head[ENTW-1:COLRW];
  assign mem_data = empty ? '0 : head[COLRW-1:0];

  // Two free slots are kept for the pixel now on the inputs and the one in stage 1.
  assign oe = (cnt + CNTW'(vld_p1)) <= CNTW'(DEPTH - 2);

  // Drained means nothing new entering, stage 1 empty and the FIFO empty after this edge.
  assign drained = !keep && !vld_p1 && (cnt_nxt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_done)   state <= FLUSH;
          else if (drawing) state <= RUN;
        end
        RUN: begin
          if (frame_done) state <= FLUSH;
        end
        FLUSH: begin
          if (drained) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == FLUSH) || vld_p1 || !empty;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: directed scenarios plus randomized traffic
// scored against an in-order write queue and an in-flight pixel count.
module tb_fb_pixel_writer;

  localparam int CORDW  = 10;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int COLRW  = 4;
  localparam int ADDRW  = 19;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDRW-1:0] a;
    logic [COLRW-1:0] c;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [CORDW-1:0] x;
  logic [CORDW-1:0] y;
  logic             drawing;
  logic [COLRW-1:0] colr;
  logic             frame_done;
  logic             oe;
  logic [ADDRW-1:0] mem_addr;
  logic [COLRW-1:0] mem_data;
  logic             mem_we;
  logic             mem_ready;
  logic             busy;
  logic             done;
  logic             overflow;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  done_cnt = 0;

  fb_pixel_writer #(
    .CORDW(CORDW), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .COLRW(COLRW), .ADDRW(ADDRW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .drawing(drawing), .colr(colr),
    .frame_done(frame_done), .oe(oe), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_ready(mem_ready), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Writes accepted by the memory are recorded mid-cycle, before the edge that pops them.
  always @(negedge clk) begin
    if (mem_we && mem_ready) got_q.push_back({mem_addr, mem_data});
    if (done) done_cnt++;
  end

  function automatic wr_t model_wr(input int px, input int py, input int pc);
    wr_t r;
    int  lin;
    lin = (py * WIDTH + px) % (1 << ADDRW);
    r.a = ADDRW'(lin);
    r.c = COLRW'(pc);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drawing    = 1'b0;
    frame_done = 1'b0;
    x          = '0;
    y          = '0;
    colr       = '0;
  endtask

  task automatic send_px(input int px, input int py, input int pc);
    x       = CORDW'(px);
    y       = CORDW'(py);
    colr    = COLRW'(pc);
    drawing = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    mem_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_cmp++; if (oe !== 1'b1)       begin n_bad++; $display("FAIL reset_oe: got %b expected 1", oe); end
    n_cmp++; if (mem_addr !== '0)   begin n_bad++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
    n_cmp++; if (mem_data !== '0)   begin n_bad++; $display("FAIL reset_mem_data: got %0d expected 0", mem_data); end
    do_reset();
  endtask

  task automatic test_single();
    wr_t e;
    mem_ready = 1'b1;
    e = model_wr(3, 2, 5);
    send_px(3, 2, 5);
    tick();
    idle_inputs();
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL single_early_we: got %b expected 0", mem_we); end
    n_cmp++; if (busy !== 1'b1)   begin n_bad++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick();
    n_cmp++; if (mem_we !== 1'b1)  begin n_bad++; $display("FAIL single_we: got %b expected 1", mem_we); end
    n_cmp++; if (mem_addr !== e.a) begin n_bad++; $display("FAIL single_addr: got %0d expected %0d", mem_addr, e.a); end
    n_cmp++; if (mem_data !== e.c) begin n_bad++; $display("FAIL single_data: got %0d expected %0d", mem_data, e.c); end
    tick();
    n_cmp++; if (mem_we !== 1'b0)     begin n_bad++; $display("FAIL single_we_len: got %b expected 0", mem_we); end
    n_cmp++; if (got_q.size() != 1)   begin n_bad++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
  endtask

  task automatic test_frame_done_last();
    wr_t e;
    int  px, py, pc, wcyc, dcyc, ndone;
    logic bz;
    logic [ADDRW-1:0] wa;
    logic [COLRW-1:0] wd;
    mem_ready = 1'b1;
    px = $urandom_range(0, WIDTH-1);
    py = $urandom_range(0, HEIGHT-1);
    pc = $urandom_range(0, 15);
    e  = model_wr(px, py, pc);
    send_px(px, py, pc);
    frame_done = 1'b1;
    tick();
    idle_inputs();
    wcyc = -1; dcyc = -1; ndone = 0; bz = 1'b1; wa = '0; wd = '0;
    for (int i = 1; i <= 10; i++) begin
      if (mem_we && wcyc < 0) begin wcyc = i; wa = mem_addr; wd = mem_data; end
      if (done) begin
        ndone++;
        if (dcyc < 0) begin dcyc = i; bz = busy; end
      end
      tick();
    end
    n_cmp++; if (wcyc != 2)        begin n_bad++; $display("FAIL fd_write_cycle: got %0d expected 2", wcyc); end
    n_cmp++; if (wa !== e.a)       begin n_bad++; $display("FAIL fd_addr: got %0d expected %0d", wa, e.a); end
    n_cmp++; if (wd !== e.c)       begin n_bad++; $display("FAIL fd_data: got %0d expected %0d", wd, e.c); end
    n_cmp++; if (dcyc != wcyc + 1) begin n_bad++; $display("FAIL fd_done_cycle: got %0d expected %0d", dcyc, wcyc + 1); end
    n_cmp++; if (ndone != 1)       begin n_bad++; $display("FAIL fd_done_pulses: got %0d expected 1", ndone); end
    n_cmp++; if (bz !== 1'b0)      begin n_bad++; $display("FAIL fd_busy_at_done: got %b expected 0", bz); end
  endtask

  task automatic test_burst();
    int sent, first_low, px, py, pc, guard;
    do_reset();
    sent = 0; first_low = -1; guard = 0;
    while (sent < 8 && guard < 60) begin
      mem_ready = (guard >= 8);
      n_cmp++;
      if (oe !== ((sent - got_q.size()) <= DEPTH - 2)) begin
        n_bad++;
        $display("FAIL burst_oe: got %b expected %b (in flight %0d)", oe, (sent - got_q.size()) <= DEPTH - 2, sent - got_q.size());
      end
      if (!oe && first_low < 0) first_low = sent - got_q.size();
      if (oe) begin
        px = $urandom_range(0, WIDTH-1); py = $urandom_range(0, HEIGHT-1); pc = $urandom_range(0, 15);
        send_px(px, py, pc);
        exp_q.push_back(model_wr(px, py, pc));
        sent++;
      end else begin
        drawing = 1'b0;
      end
      tick();
      guard++;
    end
    idle_inputs();
    mem_ready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) tick();
    n_cmp++; if (first_low != DEPTH - 1) begin n_bad++; $display("FAIL burst_oe_low_at: got %0d expected %0d", first_low, DEPTH - 1); end
    n_cmp++; if (got_q.size() != 8)      begin n_bad++; $display("FAIL burst_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL burst_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL burst_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_random();
    int sent, px, py, pc;
    logic prev_stall;
    logic [ADDRW-1:0] prev_a;
    logic [COLRW-1:0] prev_d;
    do_reset();
    sent = 0; prev_stall = 1'b0; prev_a = '0; prev_d = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_cmp++;
      if (oe !== ((sent - got_q.size()) <= DEPTH - 2)) begin
        n_bad++; $display("FAIL rand_oe: got %b expected %b at cycle %0d", oe, (sent - got_q.size()) <= DEPTH - 2, cyc);
      end
      if (prev_stall) begin
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== prev_a || mem_data !== prev_d) begin
          n_bad++; $display("FAIL rand_stall_hold: got we=%b %0d/%0d expected we=1 %0d/%0d", mem_we, mem_addr, mem_data, prev_a, prev_d);
        end
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      if (oe && $urandom_range(0, 2) != 0) begin
        px = $urandom_range(0, WIDTH-1); py = $urandom_range(0, HEIGHT-1); pc = $urandom_range(0, 15);
        send_px(px, py, pc);
        exp_q.push_back(model_wr(px, py, pc));
        sent++;
      end else begin
        drawing = 1'b0;
      end
      prev_stall = mem_we && !mem_ready;
      prev_a = mem_addr;
      prev_d = mem_data;
      tick();
    end
    idle_inputs();
    mem_ready = 1'b1;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rand_done_timeout: got %b expected 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rand_busy_at_done: got %b expected 0", busy); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_px($urandom_range(0, WIDTH-1), $urandom_range(0, HEIGHT-1), $urandom_range(0, 15));
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rstp_pending_we: got %b expected 1", mem_we); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rstp_we_in_reset: got %b expected 0", mem_we); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rstp_busy_in_reset: got %b expected 0", busy); end
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    got_q.delete();
    done_cnt = 0;
    repeat (15) tick();
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL rstp_writes_after: got %0d expected 0", got_q.size()); end
    n_cmp++; if (done_cnt != 0)     begin n_bad++; $display("FAIL rstp_done_after: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_clip();
    wr_t e;
    do_reset();
    mem_ready = 1'b1;
    e = model_wr(640, 0, 9);
    send_px(640, 0, 9);
    tick();
    idle_inputs();
    repeat (6) tick();
`ifdef PIXEL_WRITER_CLIP_EN
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL clip_dropped: got %0d writes expected 0", got_q.size()); end
`else
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL clip_written: got %0d writes expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== e) begin n_bad++; $display("FAIL clip_addr: got %h expected %h", got_q[0], e); end
    end
`endif
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clip_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    int px, py, pc;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      px = $urandom_range(0, WIDTH-1); py = $urandom_range(0, HEIGHT-1); pc = $urandom_range(0, 15);
      send_px(px, py, pc);
      if (i < DEPTH) exp_q.push_back(model_wr(px, py, pc));
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    mem_ready = 1'b1;
    repeat (10) tick();
    n_cmp++; if (got_q.size() != 6 - 2) begin n_bad++; $display("FAIL ovf_kept: got %0d expected %0d", got_q.size(), 6 - 2); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared: got %b expected 0", overflow); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame_done_last();
    test_burst();
    test_random();
    test_reset_pending();
    test_clip();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
